// File: rtl/msu_pkg.sv
// Shared constants, the state type and helpers for the redundant-to-binary converter.
//   WORD_LEN  : radix width of one output digit
//   BIT_LEN   : significant bits in one redundant coefficient
//   CARRY_LEN : width of the carry between digits (it never exceeds 2)
`ifndef MOD_LEN_DEF
`define MOD_LEN_DEF 1024
`endif

package msu_pkg;

    localparam int unsigned WORD_LEN  = 16;
    localparam int unsigned BIT_LEN   = 17;
    localparam int unsigned CARRY_LEN = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } r2b_state_t;

    // Number of groups of d digits needed to cover n digits.
    function automatic int unsigned num_steps(input int unsigned n, input int unsigned d);
        return (n + d - 1) / d;
    endfunction

endpackage

// File: rtl/redundant_to_binary_if.sv
// Handshake and data bundle for the redundant-to-binary converter.
//   sq_out_in : packed coefficients, slot j at [j*2*WORD_LEN +: 2*WORD_LEN]
//   in_valid / in_ready : input handshake
//   bin_out / carry_out : canonical binary result and the carry above it
//   out_valid / out_ready : result handshake
//   overrun : sticky flag, input offered while the converter was busy
// The converter connects through the slave modport; the producer/consumer side uses master.
interface redundant_to_binary_if #(
    parameter int unsigned NUM_ELEMENTS = 65,
    parameter int unsigned WORD_LEN     = 16
) ();

    localparam int unsigned SQ_OUT_BITS = NUM_ELEMENTS * WORD_LEN * 2;
    localparam int unsigned BIN_BITS    = NUM_ELEMENTS * WORD_LEN;

    logic [SQ_OUT_BITS-1:0] sq_out_in;
    logic                   in_valid;
    logic                   in_ready;
    logic [BIN_BITS-1:0]    bin_out;
    logic [1:0]             carry_out;
    logic                   out_valid;
    logic                   out_ready;
    logic                   overrun;

    modport master (
        output sq_out_in,
        output in_valid,
        input  in_ready,
        input  bin_out,
        input  carry_out,
        input  out_valid,
        output out_ready,
        input  overrun
    );

    modport slave (
        input  sq_out_in,
        input  in_valid,
        output in_ready,
        output bin_out,
        output carry_out,
        output out_valid,
        input  out_ready,
        output overrun
    );

endinterface

// File: rtl/carry_digit_add.sv
// One digit of the carry-propagate chain: adds the incoming carry to a redundant
// coefficient and splits the sum into an output digit and an outgoing carry.
//   coef  : BIT_LEN-bit redundant coefficient
//   cin   : incoming carry
//   digit : low WORD_LEN bits of coef + cin
//   cout  : coef + cin shifted down by WORD_LEN
module carry_digit_add #(
    parameter int unsigned WORD_LEN  = 16,
    parameter int unsigned BIT_LEN   = 17,
    parameter int unsigned CARRY_LEN = 2
) (
    input  logic [BIT_LEN-1:0]   coef,
    input  logic [CARRY_LEN-1:0] cin,
    output logic [WORD_LEN-1:0]  digit,
    output logic [CARRY_LEN-1:0] cout
);

    localparam int unsigned SUM_W = BIT_LEN + 1;

    logic [SUM_W-1:0] sum;

    always_comb begin
        sum   = {1'b0, coef} + SUM_W'(cin);
        digit = sum[WORD_LEN-1:0];
        cout  = CARRY_LEN'(sum >> WORD_LEN);
    end

endmodule

// File: rtl/redundant_to_binary.sv
// Converts the redundant squarer output into a canonical binary integer by
// propagating carries DIGITS_PER_CYCLE digits per clock.
//   clk   : clock
//   reset : asynchronous active-low reset
//   bus   : slave side of redundant_to_binary_if (input word, result, overrun flag)
// Flow: IDLE captures the coefficients, RUN resolves one digit group per cycle and
// then spends one more cycle publishing the final carry, DONE holds the result
// until out_ready.
module redundant_to_binary #(
    parameter int unsigned MOD_LEN               = `MOD_LEN_DEF,
    parameter int unsigned WORD_LEN              = msu_pkg::WORD_LEN,
    parameter int unsigned BIT_LEN               = msu_pkg::BIT_LEN,
    parameter int unsigned REDUNDANT_ELEMENTS    = 1,
    parameter int unsigned NONREDUNDANT_ELEMENTS = MOD_LEN / WORD_LEN,
    parameter int unsigned NUM_ELEMENTS          = REDUNDANT_ELEMENTS + NONREDUNDANT_ELEMENTS,
    parameter int unsigned SQ_OUT_BITS           = NUM_ELEMENTS * WORD_LEN * 2,
    parameter int unsigned DIGITS_PER_CYCLE      = 4,
    parameter int unsigned BIN_BITS              = NUM_ELEMENTS * WORD_LEN
) (
    input  logic                  clk,
    input  logic                  reset,
    redundant_to_binary_if.slave  bus
);

    import msu_pkg::*;

    localparam int unsigned SLOT_W = 2 * WORD_LEN;
    localparam int unsigned JUNK_W = SLOT_W - BIT_LEN;
    // Index runs in steps of DIGITS_PER_CYCLE up to the first value past the last digit.
    localparam int unsigned IDX_W  =
        $clog2(num_steps(NUM_ELEMENTS, DIGITS_PER_CYCLE) * DIGITS_PER_CYCLE + 1);

    r2b_state_t                              state_q, state_d;
    logic [IDX_W-1:0]                        idx_q, idx_d;
    logic [CARRY_LEN-1:0]                    carry_q, carry_d;
    logic [NUM_ELEMENTS-1:0][BIT_LEN-1:0]    coef_q, coef_d;
    logic [BIN_BITS-1:0]                     bin_q, bin_d;
    logic [CARRY_LEN-1:0]                    carry_out_q, carry_out_d;
    logic                                    out_valid_q, out_valid_d;
    logic                                    overrun_q, overrun_d;

    logic [DIGITS_PER_CYCLE-1:0][BIT_LEN-1:0]   grp_coef;
    logic [DIGITS_PER_CYCLE-1:0][WORD_LEN-1:0]  grp_digit;
    logic [DIGITS_PER_CYCLE-1:0][CARRY_LEN-1:0] grp_cout;
    logic [CARRY_LEN-1:0]                       grp_carry;
    logic [NUM_ELEMENTS*JUNK_W-1:0]             unused_slot_bits;
    int unsigned                                idx_int;

    assign idx_int = 32'(idx_q);

    // Group mux: pick coefficients idx..idx+D-1; positions past the top read as zero.
    always_comb begin
        grp_coef = '0;
        for (int unsigned k = 0; k < DIGITS_PER_CYCLE; k++) begin
            for (int unsigned e = 0; e < NUM_ELEMENTS; e++) begin
                if (e == idx_int + k) begin
                    grp_coef[k] = coef_q[e];
                end
            end
        end
    end

    for (genvar k = 0; k < DIGITS_PER_CYCLE; k++) begin : g_chain
        logic [CARRY_LEN-1:0] cin;
        logic [CARRY_LEN-1:0] cout;
        if (k == 0) begin : g_first
            assign cin = carry_q;
        end else begin : g_next
            assign cin = g_chain[k-1].cout;
        end
        carry_digit_add #(
            .WORD_LEN  (WORD_LEN),
            .BIT_LEN   (BIT_LEN),
            .CARRY_LEN (CARRY_LEN)
        ) u_add (
            .coef  (grp_coef[k]),
            .cin   (cin),
            .digit (grp_digit[k]),
            .cout  (cout)
        );
        assign grp_cout[k] = cout;
    end

    // The carry leaving the group is taken at the last real digit, so a partial final
    // group does not lose its carry into the zero-padded positions.
    always_comb begin
        grp_carry = carry_q;
        for (int unsigned k = 0; k < DIGITS_PER_CYCLE; k++) begin
            if (idx_int + k < NUM_ELEMENTS) begin
                grp_carry = grp_cout[k];
            end
        end
    end

    // Upper slot bits carry no information.
    always_comb begin
        for (int unsigned e = 0; e < NUM_ELEMENTS; e++) begin
            unused_slot_bits[e*JUNK_W +: JUNK_W] = bus.sq_out_in[e*SLOT_W + BIT_LEN +: JUNK_W];
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        coef_d      = coef_q;
        bin_d       = bin_q;
        carry_out_d = carry_out_q;
        out_valid_d = out_valid_q;
        overrun_d   = overrun_q | (bus.in_valid && (state_q != IDLE));

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    for (int unsigned e = 0; e < NUM_ELEMENTS; e++) begin
                        coef_d[e] = bus.sq_out_in[e*SLOT_W +: BIT_LEN];
                    end
                    carry_d = '0;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (idx_int < NUM_ELEMENTS) begin
                    for (int unsigned k = 0; k < DIGITS_PER_CYCLE; k++) begin
                        for (int unsigned e = 0; e < NUM_ELEMENTS; e++) begin
                            if (e == idx_int + k) begin
                                bin_d[e*WORD_LEN +: WORD_LEN] = grp_digit[k];
                            end
                        end
                    end
                    carry_d = grp_carry;
                    idx_d   = idx_q + IDX_W'(DIGITS_PER_CYCLE);
                end else begin
                    carry_out_d = carry_q;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            carry_q     <= '0;
            coef_q      <= '0;
            bin_q       <= '0;
            carry_out_q <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            coef_q      <= coef_d;
            bin_q       <= bin_d;
            carry_out_q <= carry_out_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.bin_out   = bin_q;
    assign bus.carry_out = carry_out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_redundant_to_binary.sv
// Self-checking bench for redundant_to_binary: directed corner vectors, random
// vectors against an arithmetic reference, DONE hold / overrun, and mid-run reset.
module tb_redundant_to_binary;

    localparam int NE  = 65;
    localparam int WL  = 16;
    localparam int SQB = NE * WL * 2;
    localparam int BB  = NE * WL;
    localparam int MW  = BB + 8;
    localparam int LAT = 18;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    redundant_to_binary_if #(.NUM_ELEMENTS(NE), .WORD_LEN(WL)) bus ();

    redundant_to_binary dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference: sum of coef[j] * 2^(16j), coef being the low 17 bits of each slot.
    function automatic logic [MW-1:0] model(input logic [SQB-1:0] v);
        logic [MW-1:0] acc;
        logic [MW-1:0] c;
        acc = '0;
        for (int j = 0; j < NE; j++) begin
            c   = MW'(v[j*32 +: 17]);
            acc = acc + (c << (16 * j));
        end
        return acc;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one vector, then wait (bounded) for out_valid; lat counts edges after acceptance.
    task automatic apply_and_wait(input logic [SQB-1:0] v, output int lat, output bit accepted);
        accepted = 1'b0;
        lat      = 0;
        for (int i = 0; i < 50 && !bus.in_ready; i++) step();
        if (bus.in_ready) begin
            bus.sq_out_in = v;
            bus.in_valid  = 1'b1;
            step();
            bus.in_valid  = 1'b0;
            accepted      = 1'b1;
            while (!bus.out_valid && lat < 100) begin
                step();
                lat++;
            end
        end
    endtask

    function automatic logic [SQB-1:0] random_vec(input bit junk);
        logic [SQB-1:0] v;
        logic [31:0]    slot;
        for (int j = 0; j < NE; j++) begin
            slot = 32'($urandom_range(0, 32'h1FFFF));
            if (junk) slot = slot | 32'hFFFE_0000;
            v[j*32 +: 32] = slot;
        end
        return v;
    endfunction

    task automatic test_reset();
        bus.sq_out_in = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        reset         = 1'b0;
        #12;
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset out_valid: got %b want 0", bus.out_valid);
        end
        n_cmp++;
        if (bus.bin_out !== '0) begin
            n_err++;
            $display("FAIL reset bin_out: got %h want 0", bus.bin_out);
        end
        n_cmp++;
        if (bus.carry_out !== 2'd0 || bus.overrun !== 1'b0) begin
            n_err++;
            $display("FAIL reset carry/overrun: got %0d/%b want 0/0", bus.carry_out, bus.overrun);
        end
        @(posedge clk);
        #3;
        reset = 1'b1;
        step();
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset in_ready: got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_directed();
        logic [SQB-1:0] vecs [3];
        logic [MW-1:0]  exp;
        int             lat;
        bit             acc;
        vecs[0] = '0;
        vecs[1] = '0;
        vecs[1][31:0] = 32'h0001_FFFF;
        vecs[2] = '0;
        vecs[2][31:0] = 32'h0001_0000;
        for (int j = 1; j < NE; j++) vecs[2][j*32 +: 32] = 32'h0000_FFFF;
        for (int t = 0; t < 3; t++) begin
            exp = model(vecs[t]);
            apply_and_wait(vecs[t], lat, acc);
            n_cmp++;
            if (!acc || lat != LAT) begin
                n_err++;
                $display("FAIL directed%0d latency: got acc=%b lat=%0d want acc=1 lat=%0d",
                         t, acc, lat, LAT);
            end
            n_cmp++;
            if (bus.bin_out !== exp[BB-1:0]) begin
                n_err++;
                $display("FAIL directed%0d bin_out: got %h want %h", t, bus.bin_out, exp[BB-1:0]);
            end
            n_cmp++;
            if (bus.carry_out !== exp[BB+1:BB]) begin
                n_err++;
                $display("FAIL directed%0d carry_out: got %0d want %0d",
                         t, bus.carry_out, exp[BB+1:BB]);
            end
            n_cmp++;
            if (bus.overrun !== 1'b0) begin
                n_err++;
                $display("FAIL directed%0d overrun: got %b want 0", t, bus.overrun);
            end
            bus.out_ready = 1'b1;
            step();
            bus.out_ready = 1'b0;
            n_cmp++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL directed%0d release: got out_valid=%b in_ready=%b want 0/1",
                         t, bus.out_valid, bus.in_ready);
            end
        end
    endtask

    task automatic test_random();
        logic [SQB-1:0] v;
        logic [MW-1:0]  exp;
        int             lat;
        bit             acc;
        for (int n = 0; n < 200; n++) begin
            v   = random_vec(1'b1);
            exp = model(v);
            apply_and_wait(v, lat, acc);
            n_cmp++;
            if (!acc || lat != LAT) begin
                n_err++;
                $display("FAIL random%0d latency: got acc=%b lat=%0d want acc=1 lat=%0d",
                         n, acc, lat, LAT);
            end
            n_cmp++;
            if (bus.bin_out !== exp[BB-1:0] || bus.carry_out !== exp[BB+1:BB]) begin
                n_err++;
                $display("FAIL random%0d result: got carry=%0d bin=%h want carry=%0d bin=%h",
                         n, bus.carry_out, bus.bin_out, exp[BB+1:BB], exp[BB-1:0]);
            end
            bus.out_ready = 1'b1;
            step();
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic test_hold_done();
        logic [SQB-1:0] v;
        logic [MW-1:0]  exp;
        int             lat;
        bit             acc;
        v   = random_vec(1'b0);
        exp = model(v);
        apply_and_wait(v, lat, acc);
        n_cmp++;
        if (!acc || lat != LAT) begin
            n_err++;
            $display("FAIL hold latency: got acc=%b lat=%0d want acc=1 lat=%0d", acc, lat, LAT);
        end
        for (int c = 0; c < 10; c++) begin
            step();
            n_cmp++;
            if (bus.bin_out !== exp[BB-1:0] || bus.carry_out !== exp[BB+1:BB] ||
                bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL hold cycle%0d: got v=%b rdy=%b carry=%0d bin=%h want 1/0/%0d/%h",
                         c, bus.out_valid, bus.in_ready, bus.carry_out, bus.bin_out,
                         exp[BB+1:BB], exp[BB-1:0]);
            end
        end
        bus.sq_out_in = random_vec(1'b0);
        bus.in_valid  = 1'b1;
        step();
        bus.in_valid  = 1'b0;
        n_cmp++;
        if (bus.overrun !== 1'b1) begin
            n_err++;
            $display("FAIL hold overrun: got %b want 1", bus.overrun);
        end
        n_cmp++;
        if (bus.bin_out !== exp[BB-1:0] || bus.out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL hold after drop: got v=%b bin=%h want 1/%h",
                     bus.out_valid, bus.bin_out, exp[BB-1:0]);
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        n_cmp++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.overrun !== 1'b1) begin
            n_err++;
            $display("FAIL hold release: got rdy=%b v=%b ovr=%b want 1/0/1",
                     bus.in_ready, bus.out_valid, bus.overrun);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [SQB-1:0] v;
        logic [MW-1:0]  exp;
        int             lat;
        bit             acc;
        bus.sq_out_in = random_vec(1'b1);
        bus.in_valid  = 1'b1;
        step();
        bus.in_valid  = 1'b0;
        repeat (5) step();
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.bin_out !== '0 || bus.carry_out !== 2'd0) begin
            n_err++;
            $display("FAIL midreset outputs: got v=%b carry=%0d bin=%h want 0/0/0",
                     bus.out_valid, bus.carry_out, bus.bin_out);
        end
        n_cmp++;
        if (bus.overrun !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL midreset flags: got ovr=%b rdy=%b want 0/1", bus.overrun, bus.in_ready);
        end
        #3;
        reset = 1'b1;
        step();
        v   = random_vec(1'b1);
        exp = model(v);
        apply_and_wait(v, lat, acc);
        n_cmp++;
        if (!acc || lat != LAT) begin
            n_err++;
            $display("FAIL midreset latency: got acc=%b lat=%0d want acc=1 lat=%0d", acc, lat, LAT);
        end
        n_cmp++;
        if (bus.bin_out !== exp[BB-1:0] || bus.carry_out !== exp[BB+1:BB]) begin
            n_err++;
            $display("FAIL midreset result: got carry=%0d bin=%h want carry=%0d bin=%h",
                     bus.carry_out, bus.bin_out, exp[BB+1:BB], exp[BB-1:0]);
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_hold_done();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
